pipe_stall_ctrl: RTL and testbench

Central pipeline stall controller. It produces the 6-bit stall vector consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB). It arbitrates three stall sources: ID load-use hazards, multi-cycle EX operations (tracked by an internal counter FSM), and MEM data accesses (tracked by a req/ack wait FSM with a timeout). It also handles a synchronous exception flush that aborts pending stalls.

---
 rtl/pipe_stall_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller.
// Arbitrates three stall sources into one 6-bit stall vector:
//   MEM data-access wait > multi-cycle EX operation > ID load-use hazard.
// A multi-cycle EX counter FSM and a MEM req/ack wait FSM with timeout supply
// the EX and MEM requests. An exception flush overrides every stall and aborts
// both FSMs.
// Optional: define STALL_STATS_EN to build a saturating 32-bit count of cycles
// with stall[0] set. Without it, stall_cnt is tied to zero.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [5:0]       stall,
  output logic             flush_o,
  output logic             ex_mc_done,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [31:0]      stall_cnt
);

  localparam int unsigned       WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {ExIdle, ExBusy, ExDone} ex_state_e;
  typedef enum logic {MemIdle, MemWait} mem_state_e;

  ex_state_e         ex_state_q, ex_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_state_e        mem_state_q, mem_state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              flush_q;

  logic stallreq_ex;
  logic stallreq_mem;
  logic timeout_hit;

  // The start cycle itself stalls, so the EX request covers IDLE+start too.
  assign stallreq_ex  = ((ex_state_q == ExIdle) && ex_mc_start) || (ex_state_q == ExBusy);
  assign timeout_hit  = (mem_state_q == MemWait) && (wcnt_q == WCNT_MAX);
  assign stallreq_mem = mem_req && !mem_ack && !timeout_hit;

  assign ex_mc_done = (ex_state_q == ExDone);
  assign mem_busy   = (mem_state_q == MemWait);
  assign mem_err    = timeout_hit;
  assign flush_o    = flush_q;

  // Stall vector priority encode; forced clear while in reset.
  always_comb begin
    stall = STALL_NONE;
    if (rst || flush_i) begin
      stall = STALL_NONE;
    end else if (stallreq_mem) begin
      stall = STALL_MEM;
    end else if (stallreq_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end
  end

  // EX multi-cycle FSM next state; cnt holds remaining BUSY cycles minus one.
  always_comb begin
    ex_state_d = ex_state_q;
    cnt_d      = cnt_q;
    if (flush_i) begin
      ex_state_d = ExIdle;
      cnt_d      = '0;
    end else begin
      unique case (ex_state_q)
        ExIdle: begin
          if (ex_mc_start) begin
            cnt_d      = (ex_mc_cycles == '0) ? '0 : ex_mc_cycles - CNT_W'(1);
            ex_state_d = ExBusy;
          end
        end
        ExBusy: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            ex_state_d = ExDone;
          end
        end
        ExDone: begin
          // Hold the result until the EX/MEM register can take it.
          if (!stall[3]) begin
            ex_state_d = ExIdle;
          end
        end
        default: ex_state_d = ExIdle;
      endcase
    end
  end

  // MEM wait FSM next state; wcnt counts cycles spent waiting for ack.
  always_comb begin
    mem_state_d = mem_state_q;
    wcnt_d      = wcnt_q;
    if (flush_i) begin
      mem_state_d = MemIdle;
      wcnt_d      = '0;
    end else begin
      unique case (mem_state_q)
        MemIdle: begin
          if (mem_req && !mem_ack) begin
            mem_state_d = MemWait;
            wcnt_d      = WCNT_W'(1);
          end
        end
        MemWait: begin
          if (timeout_hit || mem_ack || !mem_req) begin
            mem_state_d = MemIdle;
            wcnt_d      = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        default: mem_state_d = MemIdle;
      endcase
    end
  end

  // State registers for both FSMs and the delayed flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_state_q  <= ExIdle;
      cnt_q       <= '0;
      mem_state_q <= MemIdle;
      wcnt_q      <= '0;
      flush_q     <= 1'b0;
    end else begin
      ex_state_q  <= ex_state_d;
      cnt_q       <= cnt_d;
      mem_state_q <= mem_state_d;
      wcnt_q      <= wcnt_d;
      flush_q     <= flush_i;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (built with MEM_TIMEOUT=4).
// Each scenario is a table of per-cycle inputs and hand-derived outputs; the
// expected outputs go into a scoreboard queue when the inputs are driven and
// are popped and compared on the following falling edge.
module tb_pipe_stall_ctrl;

  localparam int unsigned CNT_W       = 6;
  localparam int unsigned MEM_TIMEOUT = 4;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;
  localparam logic [5:0] S_MEM  = 6'b011111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush_i = 1'b0;
  logic             stallreq_id = 1'b0;
  logic             ex_mc_start = 1'b0;
  logic [CNT_W-1:0] ex_mc_cycles = '0;
  logic             mem_req = 1'b0;
  logic             mem_ack = 1'b0;
  logic [5:0]       stall;
  logic             flush_o;
  logic             ex_mc_done;
  logic             mem_busy;
  logic             mem_err;
  logic [31:0]      stall_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;

  typedef struct packed {
    logic [5:0] stall;
    logic       done;
    logic       busy;
    logic       err;
    logic       flo;
  } obs_t;

  typedef struct packed {
    logic             rs;
    logic             fl;
    logic             id;
    logic             st;
    logic [CNT_W-1:0] n;
    logic             rq;
    logic             ak;
    obs_t             e;
  } row_t;

  obs_t sb[$];

  pipe_stall_ctrl #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .stallreq_id (stallreq_id),
    .ex_mc_start (ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .stall       (stall),
    .flush_o     (flush_o),
    .ex_mc_done  (ex_mc_done),
    .mem_busy    (mem_busy),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic row_t row(input logic rs, fl, id, st, input logic [CNT_W-1:0] n,
                               input logic rq, ak, input logic [5:0] s,
                               input logic dn, bs, er, fo);
    row_t r;
    r.rs = rs; r.fl = fl; r.id = id; r.st = st; r.n = n; r.rq = rq; r.ak = ak;
    r.e.stall = s; r.e.done = dn; r.e.busy = bs; r.e.err = er; r.e.flo = fo;
    return r;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.stall = stall; o.done = ex_mc_done; o.busy = mem_busy; o.err = mem_err; o.flo = flush_o;
    return o;
  endfunction

  // Drive one cycle and queue the outputs expected for it.
  task automatic drive(input row_t r);
    rst = r.rs; flush_i = r.fl; stallreq_id = r.id; ex_mc_start = r.st;
    ex_mc_cycles = r.n; mem_req = r.rq; mem_ack = r.ak;
    sb.push_back(r.e);
    if (r.rs) model_cnt = 32'd0;
    if (r.e.stall[0]) model_cnt = model_cnt + 32'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    stallreq_id = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 6'd3; mem_req = 1'b1;
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got, obs_t'('0));
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
    tick();
    got = observe();
    checks++;
    if (got !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_hold_edge: got %b want %b", got, obs_t'('0));
    end
    stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = '0; mem_req = 1'b0;
    rst = 1'b0;
    model_cnt = 32'd0;
  endtask

  task automatic test_reset_mid_busy();
    row_t r[$];
    obs_t got, want;
    r.push_back(row(0, 0, 0, 1, 6'd10, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0,  0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0,  0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(1, 0, 0, 0, 6'd0,  0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0,  0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd1,  0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0,  0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0,  0, 0, S_NONE, 1, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0,  0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_busy row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_ex_multicycle();
    row_t r[$];
    obs_t got, want;
    r.push_back(row(0, 0, 0, 1, 6'd3, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd9, 0, 0, S_EX,   0, 0, 0, 0));  // start ignored in BUSY
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd5, 0, 0, S_NONE, 1, 0, 0, 0));  // start ignored in DONE
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));  // N=0 behaves as N=1
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 1, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ex_multicycle row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    row_t r[$];
    obs_t got, want;
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 1, S_NONE, 0, 1, 0, 0));  // ack one before timeout
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 1, S_NONE, 0, 0, 0, 0));  // zero-wait access
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 1, 0, 0));  // req withdrawn in WAIT
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mem_wait row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_mem_timeout();
    row_t r[$];
    obs_t got, want;
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_NONE, 0, 1, 1, 0));  // timeout releases
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mem_timeout row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_id_mem_flush();
    row_t r[$];
    obs_t got, want;
    r.push_back(row(0, 0, 1, 0, 6'd0, 1, 0, S_MEM,  0, 0, 0, 0));
    r.push_back(row(0, 0, 1, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 1, 0, 6'd0, 1, 1, S_ID,   0, 1, 0, 0));
    r.push_back(row(0, 0, 1, 0, 6'd0, 0, 0, S_ID,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd5, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 1, 0, 1, 6'd3, 1, 0, S_NONE, 0, 0, 0, 0));  // flush with start and req
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 1));
    r.push_back(row(0, 0, 0, 1, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 1, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL id_mem_flush row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    row_t r[$];
    obs_t got, want;
    r.push_back(row(0, 0, 0, 1, 6'd1, 1, 0, S_MEM,  0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  0, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 0, S_MEM,  1, 1, 0, 0));  // DONE held by MEM stall
    r.push_back(row(0, 0, 0, 0, 6'd0, 1, 1, S_NONE, 1, 1, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
  endtask

  task automatic test_stats();
    row_t        r[$];
    obs_t        got, want;
    logic [31:0] exp_cnt;
`ifdef STALL_STATS_EN
    exp_cnt = model_cnt;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL stats_accumulated: got %0d want %0d", stall_cnt, exp_cnt);
    end
    r.push_back(row(1, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd3, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 1, 0, 0, 0));
    r.push_back(row(0, 0, 0, 1, 6'd2, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_EX,   0, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 1, 0, 0, 0));
    r.push_back(row(0, 0, 0, 0, 6'd0, 0, 0, S_NONE, 0, 0, 0, 0));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stats row %0d: got %b want %b", i, got, want);
      end
      tick();
    end
`ifdef STALL_STATS_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL stats_seven: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_ex_multicycle();
    test_mem_wait();
    test_mem_timeout();
    test_id_mem_flush();
    test_back_to_back();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
